// File: rtl/main_fsm_decoder.sv
`default_nettype none
// +-----------------------------------------------------------------------------
// | main_fsm_decoder : multicycle control FSM and instruction decoder for the
// |                    ARM-subset CPU. Optional CMP decode under MAIN_FSM_CMP_EN.
// | Revision         : 1.0 - initial release
// +-----------------------------------------------------------------------------
module main_fsm_decoder #(
  parameter int STATE_W = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] Op,
  input  logic [5:0] Funct,
  input  logic [3:0] Rd,
  output logic       IRWrite,
  output logic       AdrSrc,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ResultSrc,
  output logic       NextPC,
  output logic [1:0] ImmSrc,
  output logic [1:0] RegSrc,
  output logic [1:0] ALUControl,
  output logic [1:0] FlagW,
  output logic       RegW,
  output logic       MemW,
  output logic       PCS,
  output logic       Illegal
);

  typedef enum logic [STATE_W-1:0] {
    S_FETCH   = STATE_W'(0),
    S_DECODE  = STATE_W'(1),
    S_MEMADR  = STATE_W'(2),
    S_MEMRD   = STATE_W'(3),
    S_MEMWB   = STATE_W'(4),
    S_MEMWR   = STATE_W'(5),
    S_EXECR   = STATE_W'(6),
    S_EXECI   = STATE_W'(7),
    S_ALUWB   = STATE_W'(8),
    S_BRANCH  = STATE_W'(9),
    S_UNKNOWN = STATE_W'(10)
  } state_t;

  state_t     r_state;
  state_t     w_next;

  logic       w_irwrite;
  logic       w_adrsrc;
  logic       w_alusrca;
  logic [1:0] w_alusrcb;
  logic [1:0] w_resultsrc;
  logic       w_nextpc;
  logic       w_opdec;
  logic       w_aluop;
  logic       w_branch;
  logic       w_regw;
  logic       w_memw;
  logic       w_illegal;
  logic [1:0] w_alucontrol;
  logic [1:0] w_flagw;
  logic       w_pcs;
  logic       w_is_cmp;

`ifdef MAIN_FSM_CMP_EN
  assign w_is_cmp = (Funct[4:1] == 4'b1010);
`else
  assign w_is_cmp = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_FETCH;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = S_FETCH;
    case (r_state)
      S_FETCH:  w_next = S_DECODE;
      S_DECODE: begin
        case (Op)
          2'b01:   w_next = S_MEMADR;
          2'b00:   w_next = Funct[5] ? S_EXECI : S_EXECR;
          2'b10:   w_next = S_BRANCH;
          default: w_next = S_UNKNOWN;
        endcase
      end
      S_MEMADR: w_next = Funct[0] ? S_MEMRD : S_MEMWR;
      S_MEMRD:  w_next = S_MEMWB;
      S_EXECR:  w_next = S_ALUWB;
      S_EXECI:  w_next = S_ALUWB;
      default:  w_next = S_FETCH;
    endcase
  end

  // Per-state datapath controls; ImmSrc/RegSrc follow Op in every legal state
  // except UNKNOWN, which drives every control to zero.
  always_comb begin
    w_irwrite   = 1'b0;
    w_adrsrc    = 1'b0;
    w_alusrca   = 1'b0;
    w_alusrcb   = 2'b00;
    w_resultsrc = 2'b00;
    w_nextpc    = 1'b0;
    w_opdec     = 1'b1;
    w_aluop     = 1'b0;
    w_branch    = 1'b0;
    w_regw      = 1'b0;
    w_memw      = 1'b0;
    w_illegal   = 1'b0;
    case (r_state)
      S_FETCH: begin
        w_alusrca   = 1'b1;
        w_alusrcb   = 2'b10;
        w_resultsrc = 2'b10;
        w_irwrite   = 1'b1;
        w_nextpc    = 1'b1;
      end
      S_DECODE: begin
        w_alusrca   = 1'b1;
        w_alusrcb   = 2'b10;
        w_resultsrc = 2'b10;
      end
      S_MEMADR: w_alusrcb = 2'b01;
      S_MEMRD:  w_adrsrc  = 1'b1;
      S_MEMWB: begin
        w_resultsrc = 2'b01;
        w_regw      = 1'b1;
      end
      S_MEMWR: begin
        w_adrsrc = 1'b1;
        w_memw   = 1'b1;
      end
      S_EXECR: w_aluop = 1'b1;
      S_EXECI: begin
        w_alusrcb = 2'b01;
        w_aluop   = 1'b1;
      end
      S_ALUWB: w_regw = ~w_is_cmp;
      S_BRANCH: begin
        w_alusrcb   = 2'b01;
        w_resultsrc = 2'b10;
        w_branch    = 1'b1;
      end
      S_UNKNOWN: begin
        w_opdec   = 1'b0;
        w_illegal = 1'b1;
      end
      default: w_opdec = 1'b0;
    endcase
  end

  always_comb begin
    w_alucontrol = 2'b00;
    w_flagw      = 2'b00;
    if (w_aluop) begin
      if (w_is_cmp) begin
        w_alucontrol = 2'b01;
        w_flagw      = 2'b11;
      end else begin
        case (Funct[4:1])
          4'b0100: begin
            w_alucontrol = 2'b00;
            w_flagw      = Funct[0] ? 2'b11 : 2'b00;
          end
          4'b0010: begin
            w_alucontrol = 2'b01;
            w_flagw      = Funct[0] ? 2'b11 : 2'b00;
          end
          4'b0000: begin
            w_alucontrol = 2'b10;
            w_flagw      = Funct[0] ? 2'b10 : 2'b00;
          end
          4'b1100: begin
            w_alucontrol = 2'b11;
            w_flagw      = Funct[0] ? 2'b10 : 2'b00;
          end
          default: begin
            w_alucontrol = 2'b00;
            w_flagw      = 2'b00;
          end
        endcase
      end
    end
  end

  assign w_pcs = w_branch | (w_regw & (Rd == 4'hF));

  // Everything is held at zero while reset is asserted, fetch controls included.
  assign IRWrite    = reset & w_irwrite;
  assign AdrSrc     = reset & w_adrsrc;
  assign ALUSrcA    = reset & w_alusrca;
  assign ALUSrcB    = {2{reset}} & w_alusrcb;
  assign ResultSrc  = {2{reset}} & w_resultsrc;
  assign NextPC     = reset & w_nextpc;
  assign ImmSrc     = {2{reset & w_opdec}} & Op;
  assign RegSrc     = {2{reset & w_opdec}} & {(Op == 2'b01), (Op == 2'b10)};
  assign ALUControl = {2{reset}} & w_alucontrol;
  assign FlagW      = {2{reset}} & w_flagw;
  assign RegW       = reset & w_regw;
  assign MemW       = reset & w_memw;
  assign PCS        = reset & w_pcs;
  assign Illegal    = reset & w_illegal;

endmodule
`default_nettype wire
